mem_loader: RTL
===============

# mem_loader

Upstream loader for `top_control`: accepts a framed stream of 16-bit words (instruction count, instructions, data count, data words) over a valid/ready handshake. Writes them into IRAM and then DRAM through the processor's external write port (`addr_ext`, `iram_write_ext`, `dram_write_ext`, `start_2`, `start_3`). Finally releases the processor by raising `start`. It replaces bench-driven memory preloading in hardware builds.

## Interface
- `ADDR_W`, 9, external address width
- `DATA_W`, 16, word width
- `BASE_ADDR`, 1, first memory address written in each section
- `SETUP_CYC`, 2, cycles data/address are stable before the write strobe
- `WR_CYC`, 4, cycles the write strobe is held high
- `HOLD_CYC`, 4, cycles data/address are held after the strobe drops

- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `load_req`  in  1  single-cycle pulse starting a load; sampled only in IDLE
- `word_valid`  in  1  `word_in` is valid
- `word_in`  in  DATA_W  stream word
- `word_ready`  out  1  loader accepts a word this cycle
- `addr_ext`  out  ADDR_W  external memory address
- `Data_in_ins`  out  DATA_W  IRAM write data
- `Data_in_dram`  out  DATA_W  DRAM write data
- `iram_write_ext`  out  1  IRAM write strobe
- `dram_write_ext`  out  1  DRAM write strobe
- `start_2`  out  1  IRAM external-load mode
- `start_3`  out  1  DRAM external-load mode
- `start`  out  1  processor run enable
- `busy`  out  1  load in progress
- `error`  out  1  illegal count received; sticky until reset

## Operation
- A transfer occurs when `word_valid && word_ready` is true at a rising edge. `word_ready` is high only in GET_ICNT, I_WAIT, GET_DCNT and D_WAIT.
- States:
  - IDLE: `load_req` → GET_ICNT.
  - GET_ICNT: accept the count into `remaining`. Count 0 → GET_DCNT. Count > MAX → ERROR. Otherwise go to I_WAIT with `addr_ext` = BASE_ADDR.
  - I_WAIT: accept the word into `Data_in_ins` → I_SETUP.
  - I_SETUP (SETUP_CYC) → I_WRITE (WR_CYC, `iram_write_ext` = 1) → I_HOLD (HOLD_CYC).
  - At the end of I_HOLD: `addr_ext` += 1 and `remaining` −= 1. Next state is I_WAIT, or GET_DCNT when `remaining` reaches 0.
  - GET_DCNT, D_WAIT, D_SETUP, D_WRITE, D_HOLD mirror the instruction states, using `Data_in_dram` and `dram_write_ext`. When `remaining` reaches 0 (or the data count is 0), go to RUN.
  - RUN: `start` = 1. Terminal until reset. `load_req` and the stream are ignored.
  - ERROR: `error` = 1, no strobes, `word_ready` = 0. Terminal until reset.
- MAX = 2^ADDR_W − BASE_ADDR (511 with defaults). Counts are unsigned DATA_W values. `addr_ext` never wraps.
- Mode outputs:
  - `start_2` = 1 from GET_ICNT through I_HOLD.
  - `start_3` = 1 from GET_DCNT through D_HOLD.
  - The two are never high together. Both are 0 in IDLE, RUN and ERROR.
- `busy` = 1 in every state except IDLE, RUN and ERROR.
- `Data_in_*` and `addr_ext` change only on a word accept, at section start, or at the end of a HOLD phase. They are therefore stable across the whole SETUP/WRITE/HOLD window.

## Timing
- Reset values: `addr_ext` = BASE_ADDR. All data outputs = 0. `word_ready`, both strobes, `start_2`, `start_3`, `start`, `busy` and `error` = 0. State = IDLE.
- Reset asserted mid-operation returns to IDLE on that edge and drops any active strobe the same cycle. Memory contents already written are not touched.
- A word accepted at edge N produces:
  - strobe high from N+1+SETUP_CYC for WR_CYC cycles;
  - `word_ready` high again at N+1+SETUP_CYC+WR_CYC+HOLD_CYC.
  - Per-word minimum is 11 cycles with the defaults.
- `load_req` in IDLE → `word_ready` = 1 from the next cycle.
- Last data word's HOLD ends at edge M → `start` = 1 from M+1.
- A `word_valid` gap stalls in the WAIT/GET states indefinitely, with no timeout. Strobe timing is unaffected by upstream gaps.

## Structure
- Package `mem_loader_pkg` holds:
  - state enum localparams (IDLE, GET_ICNT, I_WAIT, I_SETUP, I_WRITE, I_HOLD, GET_DCNT, D_WAIT, D_SETUP, D_WRITE, D_HOLD, RUN, ERROR);
  - default timing constants.
- Sub-module `wr_phase_timer`: loadable down-counter that signals phase end. It is shared by SETUP, WRITE and HOLD and sized to max(SETUP_CYC, WR_CYC, HOLD_CYC).

## Test plan
- Stream 3, 10, 20, 30, 2, 7, 9 → IRAM[1..3] = 10, 20, 30 and DRAM[1..2] = 7, 9. Each strobe is exactly 4 cycles wide. `start` rises one cycle after the last hold.
- Stream 0, 0 → no strobes. `start_2` and `start_3` each high for one accept phase only. `start` = 1.
- Stream count 512 → `error` = 1, no strobes, `word_ready` = 0. A subsequent `load_req` is ignored until reset.
- Random `word_valid` gaps of 0–20 cycles with stream 2, 0xFFFF, 0x0001, 1, 0x8000 → same memory contents. Strobe widths and data stability are checked every cycle.
- `reset` asserted during the 2nd cycle of an IRAM write → strobe 0 the same cycle and all outputs at reset values. A fresh load then completes correctly.
- `load_req` and stream words presented while in RUN → `word_ready` stays 0, no strobes, `start` stays 1.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared FSM states and default timing for the stream loader
package mem_loader_pkg;
    typedef enum logic [3:0] {
        IDLE, GET_ICNT, I_WAIT, I_SETUP, I_WRITE, I_HOLD,
        GET_DCNT, D_WAIT, D_SETUP, D_WRITE, D_HOLD, RUN, ERROR
    } state_t;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_BASE_ADDR = 1;
    localparam int DEF_SETUP_CYC = 2;
    localparam int DEF_WR_CYC = 4;
    localparam int DEF_HOLD_CYC = 4;
    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
endpackage

// File: rtl/mem_loader_wr_phase_timer.sv
// wr_phase_timer: loadable down-counter; done while the current phase is in its last cycle
module wr_phase_timer
    import mem_loader_pkg::*;
#(
    parameter int MAX_CYC = max3(DEF_SETUP_CYC, DEF_WR_CYC, DEF_HOLD_CYC),
    parameter int W = $clog2(MAX_CYC + 1)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign done = cnt_q == '0;
endmodule

// File: rtl/mem_loader.sv
// mem_loader: streams instruction and data words into IRAM/DRAM through the
// external write port with fixed setup/strobe/hold timing, then releases the CPU.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BASE_ADDR = DEF_BASE_ADDR,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int WR_CYC    = DEF_WR_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              word_valid,
    input  logic [DATA_W-1:0] word_in,
    output logic              word_ready,
    output logic [ADDR_W-1:0] addr_ext,
    output logic [DATA_W-1:0] Data_in_ins,
    output logic [DATA_W-1:0] Data_in_dram,
    output logic              iram_write_ext,
    output logic              dram_write_ext,
    output logic              start_2,
    output logic              start_3,
    output logic              start,
    output logic              busy,
    output logic              error
);
    localparam int MAX_CYC = max3(SETUP_CYC, WR_CYC, HOLD_CYC);
    localparam int TW = $clog2(MAX_CYC + 1);
    localparam int MAX_CNT = 2 ** ADDR_W - BASE_ADDR;

    state_t state_q, state_d;
    logic [DATA_W-1:0] remaining_q, remaining_d, ins_q, ins_d, dram_q, dram_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic word_ready_q, word_ready_d, iram_write_q, iram_write_d, dram_write_q, dram_write_d;
    logic start_2_q, start_2_d, start_3_q, start_3_d, start_q, start_d;
    logic busy_q, busy_d, error_q, error_d;
    logic t_load, t_done, acc, too_big, last;
    logic [TW-1:0] t_val;

    assign acc = word_valid && word_ready_q;
    assign too_big = int'(word_in) > MAX_CNT;
    assign last = remaining_q == DATA_W'(1);

    wr_phase_timer #(.MAX_CYC(MAX_CYC), .W(TW)) u_timer (
        .clock(clock), .reset(reset), .load(t_load), .load_val(t_val), .done(t_done)
    );

    always_comb begin
        state_d = state_q;
        remaining_d = remaining_q;
        addr_d = addr_q;
        ins_d = ins_q;
        dram_d = dram_q;
        t_load = 1'b0;
        t_val = TW'(SETUP_CYC - 1);
        case (state_q)
            IDLE: state_d = load_req ? GET_ICNT : IDLE;
            GET_ICNT, GET_DCNT: if (acc) begin
                remaining_d = word_in;
                addr_d = ADDR_W'(BASE_ADDR);
                state_d = too_big ? ERROR
                        : word_in == '0 ? (state_q == GET_ICNT ? GET_DCNT : RUN)
                        : (state_q == GET_ICNT ? I_WAIT : D_WAIT);
            end
            I_WAIT, D_WAIT: if (acc) begin
                ins_d = state_q == I_WAIT ? word_in : ins_q;
                dram_d = state_q == D_WAIT ? word_in : dram_q;
                state_d = state_q == I_WAIT ? I_SETUP : D_SETUP;
                t_load = 1'b1;
            end
            I_SETUP, D_SETUP: if (t_done) begin
                state_d = state_q == I_SETUP ? I_WRITE : D_WRITE;
                t_load = 1'b1;
                t_val = TW'(WR_CYC - 1);
            end
            I_WRITE, D_WRITE: if (t_done) begin
                state_d = state_q == I_WRITE ? I_HOLD : D_HOLD;
                t_load = 1'b1;
                t_val = TW'(HOLD_CYC - 1);
            end
            I_HOLD, D_HOLD: if (t_done) begin
                // saturate so a full-size section never wraps back to address 0
                addr_d = &addr_q ? addr_q : addr_q + ADDR_W'(1);
                remaining_d = remaining_q - DATA_W'(1);
                state_d = state_q == I_HOLD ? (last ? GET_DCNT : I_WAIT) : (last ? RUN : D_WAIT);
            end
            default: state_d = state_q;
        endcase
        word_ready_d = state_d inside {GET_ICNT, I_WAIT, GET_DCNT, D_WAIT};
        iram_write_d = state_d == I_WRITE;
        dram_write_d = state_d == D_WRITE;
        start_2_d = state_d inside {GET_ICNT, I_WAIT, I_SETUP, I_WRITE, I_HOLD};
        start_3_d = state_d inside {GET_DCNT, D_WAIT, D_SETUP, D_WRITE, D_HOLD};
        start_d = state_d == RUN;
        error_d = state_d == ERROR;
        busy_d = !(state_d inside {IDLE, RUN, ERROR});
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            remaining_q <= '0;
            addr_q <= ADDR_W'(BASE_ADDR);
            ins_q <= '0;
            dram_q <= '0;
            word_ready_q <= 1'b0;
            iram_write_q <= 1'b0;
            dram_write_q <= 1'b0;
            start_2_q <= 1'b0;
            start_3_q <= 1'b0;
            start_q <= 1'b0;
            busy_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            remaining_q <= remaining_d;
            addr_q <= addr_d;
            ins_q <= ins_d;
            dram_q <= dram_d;
            word_ready_q <= word_ready_d;
            iram_write_q <= iram_write_d;
            dram_write_q <= dram_write_d;
            start_2_q <= start_2_d;
            start_3_q <= start_3_d;
            start_q <= start_d;
            busy_q <= busy_d;
            error_q <= error_d;
        end
    end

    assign word_ready = word_ready_q;
    assign addr_ext = addr_q;
    assign Data_in_ins = ins_q;
    assign Data_in_dram = dram_q;
    assign iram_write_ext = iram_write_q;
    assign dram_write_ext = dram_write_q;
    assign start_2 = start_2_q;
    assign start_3 = start_3_q;
    assign start = start_q;
    assign busy = busy_q;
    assign error = error_q;
endmodule
